// File: rtl/register_file_pkg.sv
// register_file_pkg: shared CPU widths, index/word types and the hardwired-zero register index
package register_file_pkg;
  localparam int DATA_W = 24;
  localparam int REG_ADDR_W = 4;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  localparam reg_idx_t ZERO_REG = 4'd0;
endpackage

// File: rtl/register_file.sv
// register_file: 16x24 GPRs, two combinational reads (RS/RT), one sync write (RD), R0 reads zero
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = register_file_pkg::DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_REGS = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] ReadRS,
  output logic [DATA_W-1:0] ReadRT
);
  if (NUM_REGS != 2**ADDR_W) begin : g_bad_cfg
    $error("NUM_REGS must equal 2**ADDR_W");
  end
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  always_comb begin
    regs_d = regs_q;
    if (RegWrite && RD != ADDR_W'(ZERO_REG)) regs_d[RD] = WriteData;
  end
  always_ff @(posedge Clock) begin
    if (Reset) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  // R0 is gated on the read side so it is zero even before the first reset
  assign ReadRS = (RS == ADDR_W'(ZERO_REG)) ? '0 : regs_q[RS];
  assign ReadRT = (RT == ADDR_W'(ZERO_REG)) ? '0 : regs_q[RT];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file
module tb_register_file;
  logic        Clock = 0;
  logic        Reset = 0;
  logic [3:0]  RS = 0, RT = 0, RD = 0;
  logic [23:0] WriteData = 0;
  logic        RegWrite = 0;
  logic [23:0] ReadRS, ReadRT;
  int checks = 0;
  int fails = 0;

  register_file dut (
    .Clock(Clock), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD),
    .WriteData(WriteData), .RegWrite(RegWrite), .ReadRS(ReadRS), .ReadRT(ReadRT)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] rd, input logic [23:0] d);
    RD = rd; WriteData = d; RegWrite = 1;
    step();
    RegWrite = 0;
  endtask

  task automatic test_r0_before_reset();
    RS = 0; RT = 0;
    #1;
    checks++;
    if (ReadRS !== 24'h0 || ReadRT !== 24'h0) begin
      fails++;
      $display("FAIL r0_pre_reset: RS=%h RT=%h expected 000000", ReadRS, ReadRT);
    end
  endtask

  task automatic test_reset();
    Reset = 1;
    step();
    Reset = 0;
    for (int i = 0; i < 16; i++) begin
      RS = 4'(i); RT = 4'(15 - i);
      #1;
      checks++;
      if (ReadRS !== 24'h0 || ReadRT !== 24'h0) begin
        fails++;
        $display("FAIL reset_read[%0d]: RS=%h RT=%h expected 000000", i, ReadRS, ReadRT);
      end
    end
  endtask

  task automatic test_basic();
    wr(6, 24'd3);
    wr(7, 24'd5);
    RS = 6; RT = 7;
    #1;
    checks++;
    if (ReadRS !== 24'd3 || ReadRT !== 24'd5) begin
      fails++;
      $display("FAIL basic: RS=%h RT=%h expected 000003 000005", ReadRS, ReadRT);
    end
  endtask

  task automatic test_write_disabled();
    RD = 6; WriteData = 24'hABCDEF; RegWrite = 0;
    step();
    RS = 6;
    #1;
    checks++;
    if (ReadRS !== 24'd3) begin
      fails++;
      $display("FAIL write_disabled: RS=%h expected 000003", ReadRS);
    end
  endtask

  task automatic test_zero_reg();
    wr(0, 24'hFFFFFF);
    RS = 0; RT = 0;
    #1;
    checks++;
    if (ReadRS !== 24'h0 || ReadRT !== 24'h0) begin
      fails++;
      $display("FAIL zero_reg: RS=%h RT=%h expected 000000", ReadRS, ReadRT);
    end
  endtask

  task automatic test_same_cycle();
    RS = 9; RT = 9; RD = 9; WriteData = 24'h123456; RegWrite = 1;
    #1;
    checks++;
    if (ReadRS !== 24'h0 || ReadRT !== 24'h0) begin
      fails++;
      $display("FAIL same_cycle_before: RS=%h RT=%h expected 000000", ReadRS, ReadRT);
    end
    step();
    RegWrite = 0;
    checks++;
    if (ReadRS !== 24'h123456 || ReadRT !== 24'h123456) begin
      fails++;
      $display("FAIL same_cycle_after: RS=%h RT=%h expected 123456", ReadRS, ReadRT);
    end
  endtask

  task automatic test_all_regs();
    logic [23:0] exp;
    for (int i = 1; i < 16; i++) wr(4'(i), 24'h010101 * 24'(i) ^ 24'hA50000);
    for (int i = 0; i < 16; i++) begin
      RS = 4'(i); RT = 4'(15 - i);
      #1;
      exp = (i == 0) ? 24'h0 : (24'h010101 * 24'(i) ^ 24'hA50000);
      checks++;
      if (ReadRS !== exp) begin
        fails++;
        $display("FAIL all_regs_rs[%0d]: got %h expected %h", i, ReadRS, exp);
      end
      exp = (i == 15) ? 24'h0 : (24'h010101 * 24'(15 - i) ^ 24'hA50000);
      checks++;
      if (ReadRT !== exp) begin
        fails++;
        $display("FAIL all_regs_rt[%0d]: got %h expected %h", 15 - i, ReadRT, exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    wr(15, 24'hFFFFFF);
    RS = 15; RT = 15;
    #1;
    checks++;
    if (ReadRS !== 24'hFFFFFF || ReadRT !== 24'hFFFFFF) begin
      fails++;
      $display("FAIL full_width: RS=%h RT=%h expected ffffff", ReadRS, ReadRT);
    end
    Reset = 1; RegWrite = 1; RD = 15; WriteData = 24'h000001;
    step();
    Reset = 0; RegWrite = 0;
    checks++;
    if (ReadRS !== 24'h0 || ReadRT !== 24'h0) begin
      fails++;
      $display("FAIL reset_priority: RS=%h RT=%h expected 000000", ReadRS, ReadRT);
    end
    RS = 9;
    #1;
    checks++;
    if (ReadRS !== 24'h0) begin
      fails++;
      $display("FAIL reset_clears_r9: got %h expected 000000", ReadRS);
    end
  endtask

  initial begin
    test_r0_before_reset();
    test_reset();
    test_basic();
    test_write_disabled();
    test_zero_reg();
    test_same_cycle();
    test_all_regs();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the 24-bit single-cycle CPU.
- Provides 16 registers of 24 bits, with two combinational read ports (RS, RT) and one synchronous write port (RD).
- Sits between instruction decode and the ALU.
- Write-back data arrives from the ALU/memory mux.

Parameters:
- DATA_W, 24, register width in bits.
- ADDR_W, 4, register-index width.
- NUM_REGS, 16, register count; must equal 2**ADDR_W.

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; clears all registers.
- RS  input  ADDR_W  index for read port A.
- RT  input  ADDR_W  index for read port B.
- RD  input  ADDR_W  index for the write port.
- WriteData  input  DATA_W  data to be written.
- RegWrite  input  1  write enable.
- ReadRS  output  DATA_W  contents of register RS.
- ReadRT  output  DATA_W  contents of register RT.

Behaviour:
- One clock (Clock), rising-edge. Reset is synchronous and active-high; it is sampled only on the Clock rising edge.
- Storage: NUM_REGS x DATA_W flops.
- Reset:
  - On a rising edge with Reset=1, all registers become 0.
  - Reset takes priority over a simultaneous write.
  - Reset asserted mid-operation discards any pending write on that edge.
- Write:
  - On a rising edge with Reset=0 and RegWrite=1, reg[RD] <= WriteData.
  - RegWrite=0: no register changes.
  - Write latency is 1 edge; the new value is visible on the read ports immediately after that edge.
- Register 0 is hardwired to zero:
  - Writes to RD=0 are ignored.
  - Reads of index 0 always return 0, including before any reset.
- Read:
  - Purely combinational: ReadRS = reg[RS], ReadRT = reg[RT], no clock latency.
  - Both ports may address the same register; both then return the same value.
- Read/write same index in the same cycle:
  - Read returns the OLD value until the rising edge, then the new value.
  - There is no write-to-read bypass. This is correct for the single-cycle datapath.
- Outputs after reset: ReadRS = ReadRT = 0 for every index.
- Before the first reset, registers 1..15 are undefined. The CPU top-level must assert Reset before execution.
- Index inputs are exactly ADDR_W bits, so no out-of-range case exists.
- Widths: WriteData is stored unmodified, with no sign/zero extension inside the block.

Decomposition:
- Shared CPU package holds:
  - DATA_W = 24 and REG_ADDR_W = 4.
  - Typedefs word_t (logic [23:0]) and reg_idx_t (logic [3:0]).
  - Constant ZERO_REG = 4'd0.
- The block is a single module, no sub-modules.
- The storage array and the two read muxes live in it directly.

Test Plan:
- Reset then read all indices: Reset=1 for one edge; sweep RS/RT over 0..15 -> ReadRS = ReadRT = 0 everywhere.
- Basic write/read:
  - RD=6, WriteData=3, RegWrite=1, one edge; then RD=7, WriteData=5, one edge.
  - RegWrite=0; RS=6, RT=7 -> ReadRS=3, ReadRT=5.
- Write disabled: RegWrite=0, RD=6, WriteData=24'hABCDEF, edge -> ReadRS (RS=6) stays 3.
- Zero register: RegWrite=1, RD=0, WriteData=24'hFFFFFF, edge; RS=0, RT=0 -> both read 0.
- Same-cycle read/write:
  - RS=RT=9 (value 0); drive RD=9, WriteData=24'h123456, RegWrite=1.
  - Before the edge, both outputs = 0; after the edge, both = 24'h123456.
- Reset priority and full width:
  - Write 24'hFFFFFF to R15 and confirm the read gives 24'hFFFFFF.
  - Then assert Reset=1 with RegWrite=1, RD=15, WriteData=24'h000001 on the same edge -> R15 reads 0.
